multiplier_cla: RTL and testbench

- Sequential unsigned shift-and-add multiplier.
- Each partial-product accumulation goes through a carry-lookahead (CLA) adder.
- Takes a multicand and a multiplier, iterates one multiplier bit per clock, and returns the full-width product with a done pulse.
- Used as the multiply datapath block in the lab ALU/processor; replaces a ripple-carry array.

---
 rtl/multiplier_cla_pkg.sv | 15 +
 rtl/multiplier_cla_adder.sv | 78 +++++++
 rtl/multiplier_cla.sv | 111 +++++++++++
 tb/tb_multiplier_cla.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/multiplier_cla_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package multiplier_cla_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int CLA_GROUP = 4;

  function automatic int count_width(input int m);
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/multiplier_cla_adder.sv
// Two-level carry-lookahead adder: 4-bit groups with a lookahead unit over the group carries.
// Widths that are not a multiple of the group size are zero-padded internally.
module cla_adder
  import multiplier_cla_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int GROUPS = (WIDTH + CLA_GROUP - 1) / CLA_GROUP;
  localparam int PW     = GROUPS * CLA_GROUP;

  logic [PW-1:0]     a_ext, b_ext, p, g;
  logic [PW:0]       c;
  logic [GROUPS-1:0] grp_g, grp_p;
  logic [GROUPS:0]   grp_c;
  logic              term, acc;

  // Every carry is expanded into a flat sum of products, so no ripple spans more than one group.
  always_comb begin
    a_ext = PW'(a);
    b_ext = PW'(b);
    p     = a_ext ^ b_ext;
    g     = a_ext & b_ext;
    term  = 1'b0;
    acc   = 1'b0;
    grp_g = '0;
    grp_p = '0;
    grp_c = '0;
    c     = '0;

    for (int k = 0; k < GROUPS; k++) begin
      grp_p[k] = &p[k*CLA_GROUP +: CLA_GROUP];
      acc = 1'b0;
      for (int i = 0; i < CLA_GROUP; i++) begin
        term = g[k*CLA_GROUP+i];
        for (int j = i + 1; j < CLA_GROUP; j++) term = term & p[k*CLA_GROUP+j];
        acc = acc | term;
      end
      grp_g[k] = acc;
    end

    grp_c[0] = cin;
    for (int k = 0; k < GROUPS; k++) begin
      acc = cin;
      for (int j = 0; j <= k; j++) acc = acc & grp_p[j];
      for (int i = 0; i <= k; i++) begin
        term = grp_g[i];
        for (int j = i + 1; j <= k; j++) term = term & grp_p[j];
        acc = acc | term;
      end
      grp_c[k+1] = acc;
    end

    for (int k = 0; k < GROUPS; k++) begin
      for (int i = 0; i < CLA_GROUP; i++) begin
        acc = grp_c[k];
        for (int j = 0; j < i; j++) acc = acc & p[k*CLA_GROUP+j];
        for (int m2 = 0; m2 < i; m2++) begin
          term = g[k*CLA_GROUP+m2];
          for (int j = m2 + 1; j < i; j++) term = term & p[k*CLA_GROUP+j];
          acc = acc | term;
        end
        c[k*CLA_GROUP+i] = acc;
      end
    end
    c[PW] = grp_c[GROUPS];
  end

  assign sum  = p[WIDTH-1:0] ^ c[WIDTH-1:0];
  assign cout = c[WIDTH];

endmodule

// File: rtl/multiplier_cla.sv
// Sequential unsigned shift-and-add multiplier, one multiplier bit per clock through a CLA adder.
// Define MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
module multiplier_cla
  import multiplier_cla_pkg::*;
#(
  parameter int N = 32,
  parameter int M = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   multicand,
  input  logic [M-1:0]   multiplier,
  output logic           busy,
  output logic           done,
  output logic [N+M-1:0] product
);

  localparam int W  = N + M;
  localparam int CW = count_width(M);

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  product_q, product_d;
  logic [M-1:0]  b_q, b_d;
  logic [CW-1:0] count_q, count_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [W-1:0]  sum;
  logic          sum_cout;
  logic          last_iter;

  cla_adder #(.WIDTH(W)) u_adder (
    .a    (acc_q),
    .b    (a_q),
    .cin  (1'b0),
    .sum  (sum),
    .cout (sum_cout)
  );

`ifdef MULT_EARLY_TERM_EN
  assign last_iter = (b_q >> 1) == '0;
`else
  assign last_iter = count_q == CW'(M - 1);
`endif

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    count_d   = count_q;
    product_d = product_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = W'(multicand);
          b_d     = multiplier;
          acc_d   = '0;
          count_d = '0;
          busy_d  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (b_q[0]) acc_d = sum;
        a_d     = a_q << 1;
        b_d     = b_q >> 1;
        count_d = count_q + CW'(1);
        if (last_iter) begin
          product_d = acc_d;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_multiplier_cla.sv
// Directed and randomized checks of multiplier_cla (N=M=32); latency expectations follow MULT_EARLY_TERM_EN.
module tb_multiplier_cla;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] multicand = '0;
  logic [31:0] multiplier = '0;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] vec_a [7] = '{32'd2, 32'd10, 32'd165, 32'd4660, 32'd703710, 32'hFFFFFFFF, 32'h12345678};
  logic [31:0] vec_b [7] = '{32'd1, 32'd3, 32'd15, 32'd42, 32'd18, 32'hFFFFFFFF, 32'd0};
  logic [63:0] vec_p [7] = '{64'd2, 64'd30, 64'd2475, 64'd195720, 64'd12666780,
                             64'hFFFFFFFE00000001, 64'd0};

  multiplier_cla #(.N(32), .M(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .multicand  (multicand),
    .multiplier (multiplier),
    .busy       (busy),
    .done       (done),
    .product    (product)
  );

  always #5 clk = ~clk;

  function automatic int exp_lat(input logic [31:0] b);
    int l;
    l = 32;
`ifdef MULT_EARLY_TERM_EN
    l = 1;
    for (int i = 0; i < 32; i++) if (b[i]) l = i + 1;
`else
    if (b === 32'bx) l = 0;
`endif
    return l;
  endfunction

  // Launch one operation and count clock edges from acceptance until done is seen.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] p, output int cyc);
    @(negedge clk);
    multicand  = a;
    multiplier = b;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while (done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    p = product;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    n_vec++;
    if (done !== 1'b0) begin n_err++; $display("[TB] FAIL reset_done got %b want 0", done); end
    n_vec++;
    if (product !== 64'd0) begin n_err++; $display("[TB] FAIL reset_product got %h want 0", product); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [63:0] p;
    int cyc;
    for (int i = 0; i < 7; i++) begin
      run_op(vec_a[i], vec_b[i], p, cyc);
      n_vec++;
      if (p !== vec_p[i]) begin
        n_err++;
        $display("[TB] FAIL dir_product[%0d] got %h want %h", i, p, vec_p[i]);
      end
      n_vec++;
      if (cyc != exp_lat(vec_b[i])) begin
        n_err++;
        $display("[TB] FAIL dir_latency[%0d] got %0d want %0d", i, cyc, exp_lat(vec_b[i]));
      end
      @(negedge clk);
      n_vec++;
      if (done !== 1'b0) begin n_err++; $display("[TB] FAIL dir_done_width[%0d] got %b want 0", i, done); end
      n_vec++;
      if (product !== vec_p[i]) begin
        n_err++;
        $display("[TB] FAIL dir_product_hold[%0d] got %h want %h", i, product, vec_p[i]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int cyc;
    @(negedge clk);
    multicand  = 32'd1000;
    multiplier = 32'h80000001;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while (done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 5) begin
        multicand  = 32'd5;
        multiplier = 32'd5;
        start      = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    n_vec++;
    if (product !== 64'd2147483649000) begin
      n_err++;
      $display("[TB] FAIL ignore_product got %0d want 2147483649000", product);
    end
    n_vec++;
    if (cyc != 32) begin n_err++; $display("[TB] FAIL ignore_latency got %0d want 32", cyc); end
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL ignore_idle got %b want 0", busy); end
  endtask

  task automatic test_abort();
    logic [63:0] p;
    int cyc;
    int seen;
    @(negedge clk);
    multicand  = 32'd7;
    multiplier = 32'd9;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL abort_busy got %b want 0", busy); end
    n_vec++;
    if (product !== 64'd0) begin n_err++; $display("[TB] FAIL abort_product got %0d want 0", product); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) seen++;
      @(negedge clk);
    end
    n_vec++;
    if (seen != 0) begin n_err++; $display("[TB] FAIL abort_no_done got %0d pulses want 0", seen); end
    run_op(32'd7, 32'd9, p, cyc);
    n_vec++;
    if (p !== 64'd63) begin n_err++; $display("[TB] FAIL abort_restart got %0d want 63", p); end
    n_vec++;
    if (cyc != exp_lat(32'd9)) begin
      n_err++;
      $display("[TB] FAIL abort_restart_latency got %0d want %0d", cyc, exp_lat(32'd9));
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    @(negedge clk);
    multicand  = 32'd3;
    multiplier = 32'd5;
    start      = 1'b1;
    for (int op = 0; op < 2; op++) begin
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL b2b_accept[%0d] got busy=%b done=%b want busy=1 done=0", op, busy, done);
      end
      cyc = 0;
      while (done !== 1'b1 && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      n_vec++;
      if (product !== 64'd15) begin n_err++; $display("[TB] FAIL b2b_product[%0d] got %0d want 15", op, product); end
      n_vec++;
      if (cyc != exp_lat(32'd5)) begin
        n_err++;
        $display("[TB] FAIL b2b_latency[%0d] got %0d want %0d", op, cyc, exp_lat(32'd5));
      end
    end
    start = 1'b0;
    @(negedge clk);
    repeat (40) @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [63:0] p, want;
    int cyc;
    for (int i = 0; i < 200; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 3 == 0) b = b >> $urandom_range(31, 0);
      want = {32'd0, a} * {32'd0, b};
      run_op(a, b, p, cyc);
      n_vec++;
      if (p !== want) begin n_err++; $display("[TB] FAIL rand_product[%0d] %0d*%0d got %0d want %0d", i, a, b, p, want); end
      n_vec++;
      if (cyc != exp_lat(b)) begin n_err++; $display("[TB] FAIL rand_latency[%0d] got %0d want %0d", i, cyc, exp_lat(b)); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
